mem_arbiter: RTL and testbench

- Arbitrates the single shared instruction/data memory between the fetch port (read-only) and the load/store port (read/write, byte mask).
- Sits between the core's fetch/LSU and the memory, which has a one-cycle read latency.
- Data accesses take priority; a starvation counter guarantees fetch forward progress.
- Translates fetch addresses from the core address map to memory offsets.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_arbiter_starve_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the instruction/data memory arbiter and the memory itself.
package mem_pkg;

  // Which requester owns a memory access (and therefore its response).
  typedef enum logic {
    OWNER_IF   = 1'b0,
    OWNER_DATA = 1'b1
  } mem_owner_e;

  // Core address of the instruction memory; fetch PCs are rebased against it.
  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

  // Native bus geometry of the shared memory.
  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  // One memory access as presented to the memory.
  typedef struct packed {
    logic                  we;
    logic [MEM_MASK_W-1:0] mask;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage : mem_pkg

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive denied fetch cycles.
// o_sat tells the arbiter that fetch must win the next contested cycle.
module starve_counter #(
  parameter  int LIMIT = 4,
  localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic          o_sat,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(LIMIT));

  // Clear has priority; otherwise count up and hold at the limit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // With LIMIT = 0 the counter is permanently saturated, so fetch always wins.
  assign o_sat = w_at_limit;
  assign o_cnt = r_cnt;

endmodule : starve_counter

// File: rtl/mem_arbiter.sv
// Arbiter for the shared instruction/data memory.
// Handshake: a requester raises req and holds req plus all of its fields
// stable until the cycle in which it sees its gnt; gnt is combinational and
// means the access was taken by memory this cycle. Exactly one cycle later the
// matching rvalid pulses with mem_rdata (for writes it is a completion). There
// is no backpressure on responses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter  int          DATA_WIDTH   = MEM_DATA_W,
  parameter  int          ADDR_WIDTH   = MEM_ADDR_W,
  localparam int          MASK_SIZE    = DATA_WIDTH / 8,
  parameter  logic [31:0] IMEM_BASE    = IMEM_BASE_DEFAULT,
  parameter  int          STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  // fetch port (read only)
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MASK_SIZE-1:0]  d_mask,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // memory port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MASK_SIZE-1:0]  mem_mask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic       w_starve_sat;
  logic [SCW-1:0] w_starve_cnt;
  logic       w_starve_inc;
  logic       w_d_wins;
  logic       w_sel_valid;
  mem_owner_e w_sel_owner;
  mem_req_t   w_mem;

  logic       r_rsp_valid;
  mem_owner_e r_rsp_owner;

  // Data has priority unless fetch has been starved up to the limit.
  assign w_d_wins = d_req && !(if_req && w_starve_sat);

  // Pick the owner and build the memory access from its fields.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_owner = OWNER_IF;
    w_mem       = '0;
    if (w_d_wins) begin
      w_sel_valid = 1'b1;
      w_sel_owner = OWNER_DATA;
      w_mem.we    = d_we;
      w_mem.mask  = d_mask;
      w_mem.addr  = d_addr;
      w_mem.wdata = d_wdata;
    end else if (if_req) begin
      w_sel_valid = 1'b1;
      w_sel_owner = OWNER_IF;
      w_mem.we    = 1'b0;
      w_mem.mask  = '1;
      // Rebasing wraps modulo 2^ADDR_WIDTH; PCs below the base are legal.
      w_mem.addr  = if_addr - ADDR_WIDTH'(IMEM_BASE);
      w_mem.wdata = '0;
    end
  end

  assign mem_req   = if_req | d_req;
  assign mem_we    = w_mem.we;
  assign mem_mask  = w_mem.mask;
  assign mem_addr  = w_mem.addr;
  assign mem_wdata = w_mem.wdata;

  assign if_gnt = w_sel_valid && (w_sel_owner == OWNER_IF)   && mem_gnt;
  assign d_gnt  = w_sel_valid && (w_sel_owner == OWNER_DATA) && mem_gnt;

  // A memory stall counts as a denial for fetch, just like losing to data.
  assign w_starve_inc = if_req && !if_gnt;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk    (clk),
    .arst_n (arst_n),
    .i_inc  (w_starve_inc),
    .i_clr  (!w_starve_inc),
    .o_sat  (w_starve_sat),
    .o_cnt  (w_starve_cnt)
  );

  // Track who owns the access in flight so its response is routed back.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWNER_IF;
    end else begin
      r_rsp_valid <= mem_req && mem_gnt;
      r_rsp_owner <= w_sel_owner;
    end
  end

  assign if_rvalid = r_rsp_valid && (r_rsp_owner == OWNER_IF);
  assign d_rvalid  = r_rsp_valid && (r_rsp_owner == OWNER_DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data paths, priority with starvation
// relief, memory stalls, reset mid-transaction and fetch address wrap-around.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = DW / 8;

  // clock/reset
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [MW-1:0] d_mask = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [MW-1:0] mem_mask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .IMEM_BASE    (32'h8000_0000),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_mask    (d_mask),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_mask  (mem_mask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata)
  );

  // checker
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver: move to the next negedge (mid-cycle, away from the active edge)
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_both(input logic gnt);
    if_req  = 1'b1;
    if_addr = 32'h8000_0100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_mask  = 4'hF;
    d_addr  = 32'h0000_0200;
    d_wdata = '0;
    mem_gnt = gnt;
  endtask

  task automatic drive_idle();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    mem_gnt = 1'b1;
  endtask

  logic prev_if_gnt;

  initial begin
    // reset state
    #2;
    check_eq("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("rst_d_rvalid",  64'(d_rvalid),  64'd0);
    check_eq("rst_if_gnt",    64'(if_gnt),    64'd0);
    check_eq("rst_d_gnt",     64'(d_gnt),     64'd0);
    check_eq("rst_mem_req",   64'(mem_req),   64'd0);
    next_cycle();
    arst_n = 1'b1;

    // fetch read with address rebasing
    next_cycle();
    if_req = 1'b1; if_addr = 32'h8000_0010; mem_gnt = 1'b1;
    #1;
    check_eq("if_gnt",       64'(if_gnt),    64'd1);
    check_eq("if_d_gnt",     64'(d_gnt),     64'd0);
    check_eq("if_mem_addr",  64'(mem_addr),  64'h0000_0010);
    check_eq("if_mem_we",    64'(mem_we),    64'd0);
    check_eq("if_mem_mask",  64'(mem_mask),  64'hF);
    check_eq("if_mem_wdata", 64'(mem_wdata), 64'd0);
    next_cycle();
    drive_idle();
    mem_rdata = 32'h1234_5678;
    #1;
    check_eq("if_rvalid",   64'(if_rvalid), 64'd1);
    check_eq("if_d_rvalid", 64'(d_rvalid),  64'd0);
    check_eq("if_rdata",    64'(if_rdata),  64'h1234_5678);
    check_eq("idle_mem_req", 64'(mem_req),  64'd0);

    // data write pass-through and completion
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_mask = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_mem_we",    64'(mem_we),    64'd1);
    check_eq("wr_mem_mask",  64'(mem_mask),  64'h3);
    check_eq("wr_mem_addr",  64'(mem_addr),  64'h40);
    check_eq("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check_eq("wr_d_gnt",     64'(d_gnt),     64'd1);
    check_eq("wr_if_gnt",    64'(if_gnt),    64'd0);
    next_cycle();
    drive_idle();
    #1;
    check_eq("wr_d_rvalid",  64'(d_rvalid),  64'd1);
    check_eq("wr_if_rvalid", 64'(if_rvalid), 64'd0);

    // data read, unaligned low bits forwarded untouched
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_mask = 4'hF; d_addr = 32'h43; d_wdata = '0;
    #1;
    check_eq("rd_mem_addr", 64'(mem_addr), 64'h43);
    check_eq("rd_mem_we",   64'(mem_we),   64'd0);
    check_eq("rd_d_gnt",    64'(d_gnt),    64'd1);
    next_cycle();
    drive_idle();
    mem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("rd_d_rvalid", 64'(d_rvalid), 64'd1);
    check_eq("rd_d_rdata",  64'(d_rdata),  64'hCAFE_F00D);

    // contention: D D D D IF repeating, response owner follows the grant
    prev_if_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive_both(1'b1);
      #1;
      check_eq($sformatf("pat_if_gnt_%0d", i), 64'(if_gnt), 64'((i % 5) == 4));
      check_eq($sformatf("pat_d_gnt_%0d", i),  64'(d_gnt),  64'((i % 5) != 4));
      if (i > 0) begin
        check_eq($sformatf("pat_if_rvalid_%0d", i), 64'(if_rvalid), 64'(prev_if_gnt));
        check_eq($sformatf("pat_d_rvalid_%0d", i),  64'(d_rvalid),  64'(!prev_if_gnt));
      end
      prev_if_gnt = ((i % 5) == 4);
    end
    next_cycle();
    drive_idle();
    #1;
    check_eq("pat_last_if_rvalid", 64'(if_rvalid), 64'd1);

    // memory stall: no grants/responses; stalls count toward starvation
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_both(1'b0);
      #1;
      check_eq($sformatf("stall_gnt_%0d", i),    64'({if_gnt, d_gnt}),       64'd0);
      check_eq($sformatf("stall_rvalid_%0d", i), 64'({if_rvalid, d_rvalid}), 64'd0);
    end
    next_cycle();
    drive_both(1'b1);
    #1;
    check_eq("unstall_d_gnt",   64'(d_gnt), 64'd1);
    check_eq("unstall_rvalid0", 64'({if_rvalid, d_rvalid}), 64'd0);
    next_cycle();
    #1;
    check_eq("unstall_if_gnt",  64'(if_gnt),   64'd1);
    check_eq("unstall_d_rvalid", 64'(d_rvalid), 64'd1);
    next_cycle();
    #1;
    check_eq("unstall_d_gnt2",   64'(d_gnt),     64'd1);
    check_eq("unstall_if_rvalid", 64'(if_rvalid), 64'd1);
    next_cycle();
    drive_idle();

    // reset with a fetch response pending
    next_cycle();
    if_req = 1'b1; if_addr = 32'h8000_0020; mem_gnt = 1'b1;
    #1;
    check_eq("rstmid_if_gnt", 64'(if_gnt), 64'd1);
    #2;
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstmid_if_rvalid", 64'(if_rvalid), 64'd0);
    check_eq("rstmid_d_rvalid",  64'(d_rvalid),  64'd0);
    next_cycle();
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_both(1'b1);
      #1;
      check_eq($sformatf("post_rst_if_gnt_%0d", i), 64'(if_gnt), 64'(i == 4));
      check_eq($sformatf("post_rst_d_gnt_%0d", i),  64'(d_gnt),  64'(i != 4));
      if (i == 0) check_eq("post_rst_if_rvalid", 64'(if_rvalid), 64'd0);
      next_cycle();
    end
    drive_idle();

    // fetch PC below the base wraps around
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0000_0004; mem_gnt = 1'b1;
    #1;
    check_eq("wrap_mem_addr", 64'(mem_addr), 64'h8000_0004);
    check_eq("wrap_if_gnt",   64'(if_gnt),   64'd1);
    check_eq("wrap_mem_req",  64'(mem_req),  64'd1);
    next_cycle();
    drive_idle();
    #1;
    check_eq("wrap_if_rvalid", 64'(if_rvalid), 64'd1);

    // report
    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_arbiter
